// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Multi-cycle WIDTH-bit magnitude comparator. Operands are walked MSB-first,
// DIGIT bits per clock, and the walk stops at the first chunk that differs.
// A start/done handshake lets slow sequencing logic use it without a wide
// combinational compare path. Signed operands are handled by flipping the
// sign bit at latch time (offset binary), so the datapath is purely unsigned.

module serial_magnitude_comparator #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  // Flipping the MSB maps two's complement onto offset binary, which orders
  // the same way under an unsigned compare.
  localparam logic [WIDTH-1:0] MSB_MASK =
    (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] chunk_a;
  logic [DIGIT-1:0] chunk_b;

  // The chunk under test is always the top DIGIT bits of each shift register.
  assign chunk_a = sh_a[WIDTH-1 -: DIGIT];
  assign chunk_b = sh_b[WIDTH-1 -: DIGIT];

  // Control FSM with registered handshake and result flags. Flags only change
  // on completion, so they hold the last result while a new compare runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a ^ MSB_MASK;
            sh_b  <= b ^ MSB_MASK;
            count <= CW'(N);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (chunk_a != chunk_b) begin
            gt    <= (chunk_a > chunk_b);
            lt    <= (chunk_a < chunk_b);
            eq    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count > CW'(1)) begin
            sh_a  <= sh_a << DIGIT;
            sh_b  <= sh_b << DIGIT;
            count <= count - CW'(1);
          end else begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator
// Directed bench for three comparator configurations: a 2-bit unsigned
// instance for an exhaustive sweep, and 8-bit unsigned and signed instances
// for early-exit, handshake and reset cases. Only the selected instance sees
// start, so the others stay idle.

module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  int         sel = 0;

  logic start_w2, start_u8, start_s8;
  logic busy_w2, done_w2, gt_w2, eq_w2, lt_w2;
  logic busy_u8, done_u8, gt_u8, eq_u8, lt_u8;
  logic busy_s8, done_s8, gt_s8, eq_s8, lt_s8;
  logic s_busy, s_done;
  logic [2:0] s_flags;

  int tests_run = 0;
  int tests_failed = 0;

  serial_magnitude_comparator #(.WIDTH(2), .DIGIT(1), .SIGNED(0)) u_w2 (
    .clk(clk), .rst(rst), .start(start_w2), .a(a[1:0]), .b(b[1:0]),
    .busy(busy_w2), .done(done_w2), .gt(gt_w2), .eq(eq_w2), .lt(lt_w2));

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(0)) u_u8 (
    .clk(clk), .rst(rst), .start(start_u8), .a(a), .b(b),
    .busy(busy_u8), .done(done_u8), .gt(gt_u8), .eq(eq_u8), .lt(lt_u8));

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1)) u_s8 (
    .clk(clk), .rst(rst), .start(start_s8), .a(a), .b(b),
    .busy(busy_s8), .done(done_s8), .gt(gt_s8), .eq(eq_s8), .lt(lt_s8));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Route start to the selected instance only.
  always_comb begin
    start_w2 = start && (sel == 0);
    start_u8 = start && (sel == 1);
    start_s8 = start && (sel == 2);
  end

  // Present the selected instance's outputs as one set, flags as {gt,eq,lt}.
  always_comb begin
    case (sel)
      0:       begin s_busy = busy_w2; s_done = done_w2; s_flags = {gt_w2, eq_w2, lt_w2}; end
      1:       begin s_busy = busy_u8; s_done = done_u8; s_flags = {gt_u8, eq_u8, lt_u8}; end
      default: begin s_busy = busy_s8; s_done = done_s8; s_flags = {gt_s8, eq_s8, lt_s8}; end
    endcase
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Wait (bounded) for done on the selected instance; returns the number of
  // cycles after the accepting edge, or 0 if it never came.
  task automatic waitDone(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (s_done) begin
        lat = k;
        break;
      end
    end
  endtask

  // One full compare on instance `which`: latency, result, then the cycle
  // after done must drop done and keep the flags.
  task automatic applyStimulus(input string tag, input int which,
                               input logic [7:0] av, input logic [7:0] bv,
                               input logic [2:0] exp_flags, input int exp_lat);
    int lat;
    sel = which;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;
    checkOutput({tag, "_busy"}, 32'(s_busy), 32'd1);
    waitDone(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_flags"}, 32'(s_flags), 32'(exp_flags));
    @(posedge clk); #1;
    checkOutput({tag, "_done_drop"}, 32'(s_done), 32'd0);
    checkOutput({tag, "_hold"}, 32'(s_flags), 32'(exp_flags));
  endtask

  initial begin
    int lat;
    logic [2:0] exp_f;

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_w2", 32'({busy_w2, done_w2, gt_w2, eq_w2, lt_w2}), 32'd0);
    checkOutput("rst_u8", 32'({busy_u8, done_u8, gt_u8, eq_u8, lt_u8}), 32'd0);
    checkOutput("rst_s8", 32'({busy_s8, done_s8, gt_s8, eq_s8, lt_s8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive 2-bit sweep; the MSB decides in cycle 1 when it differs.
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        exp_f = {av > bv, av == bv, av < bv};
        applyStimulus($sformatf("w2_%0d_%0d", av, bv), 0, 8'(av), 8'(bv),
                      exp_f, ((av / 2) != (bv / 2)) ? 1 : 2);
      end
    end

    // 8-bit unsigned early exit.
    applyStimulus("u8_A5_25", 1, 8'hA5, 8'h25, 3'b100, 1);
    applyStimulus("u8_30_31", 1, 8'h30, 8'h31, 3'b001, 4);
    applyStimulus("u8_3C_3C", 1, 8'h3C, 8'h3C, 3'b010, 4);

    // 8-bit signed.
    applyStimulus("s8_80_01", 2, 8'h80, 8'h01, 3'b001, 1);
    applyStimulus("s8_FF_FE", 2, 8'hFF, 8'hFE, 3'b100, 4);
    applyStimulus("s8_7F_80", 2, 8'h7F, 8'h80, 3'b100, 1);

    // Handshake: start held while busy is ignored, then accepted on done.
    sel = 1;
    @(negedge clk);
    a = 8'h10; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00;
    waitDone(lat);
    checkOutput("hs_first_lat", 32'(lat), 32'd4);
    checkOutput("hs_first_flags", 32'(s_flags), 32'(3'b001));
    @(posedge clk); #1;
    checkOutput("hs_accept_busy", 32'(s_busy), 32'd1);
    checkOutput("hs_accept_done", 32'(s_done), 32'd0);
    checkOutput("hs_accept_hold", 32'(s_flags), 32'(3'b001));
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("hs_second_done", 32'(s_done), 32'd1);
    checkOutput("hs_second_flags", 32'(s_flags), 32'(3'b100));
    @(posedge clk); #1;
    checkOutput("hs_second_drop", 32'(s_done), 32'd0);

    // Reset mid-operation clears everything at once, with no done pulse.
    @(negedge clk);
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_now", 32'({s_busy, s_done, s_flags}), 32'd0);
    @(posedge clk); #1;
    checkOutput("mid_rst_held", 32'({s_busy, s_done, s_flags}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_rst_02_01", 1, 8'h02, 8'h01, 3'b100, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Parametrised multi-cycle magnitude comparator. It generalises the team's 2-bit combinational greater-than block to WIDTH-bit operands, an unsigned or signed mode, and full gt/eq/lt outputs. Operands are compared MSB-first, DIGIT bits per clock, and the comparison terminates early on the first differing digit. It sits behind a start/done handshake so it can be used by sequencing logic that cannot afford a wide combinational compare path.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT and at least 2.
DIGIT, 2, bits compared per cycle; 1..WIDTH.
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
clk  input  1  single clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a comparison; accepted only when busy=0.
a  input  WIDTH  operand A; sampled on the accepting edge only.
b  input  WIDTH  operand B; sampled on the accepting edge only.
busy  output  1  high while a comparison is in progress.
done  output  1  one-cycle pulse when gt/eq/lt hold a new result.
gt  output  1  A > B for the most recent completed comparison.
eq  output  1  A == B for the most recent completed comparison.
lt  output  1  A < B for the most recent completed comparison.

Behaviour:
- Reset (asynchronous, any time including mid-compare):
  - FSM goes to IDLE.
  - busy, done, gt, eq and lt all go to 0.
  - Internal shift registers and the counter clear.
- FSM has two states: IDLE and RUN. N = WIDTH/DIGIT chunks.
- IDLE:
  - busy=0.
  - When start=1 on an edge: latch a and b into shift registers, load the chunk counter with N, go to RUN, and set busy=1.
  - Signed mode: at latch time, invert the MSB of both latched operands. This converts to offset binary, so an unsigned compare gives the signed result.
- RUN, one chunk per edge, taken from the top DIGIT bits of each shift register:
  - Chunks differ: register gt or lt (the other two flags cleared), pulse done=1 for the next cycle, busy=0, go to IDLE. Any remaining chunks are skipped.
  - Chunks equal and counter > 1: shift both registers left by DIGIT and decrement the counter.
  - Chunks equal and counter = 1: register eq=1 (gt=lt=0), pulse done, busy=0, go to IDLE.
- Latency: done is high k cycles after the accepting edge, where k is the index (1..N) of the first differing chunk, or N for equal operands. Worst case is N cycles.
- Results: gt/eq/lt hold their value until the next done. They are unchanged while busy.
- Result flags: after the first completion exactly one of gt/eq/lt is 1. Before that, all three are 0.
- start while busy=1 is ignored; operands are not re-sampled.
- start during the done cycle is accepted (busy=0 then), giving back-to-back operation with no dead cycle.
- done is never high for 2 consecutive cycles unless a new start was accepted in between.
- Operands a/b may change freely after the accepting edge without affecting the result.

Test Plan:
- Exhaustive sweep at WIDTH=2, DIGIT=1, SIGNED=0: all 16 {a,b} values, one start each -> gt = (a>b), eq = (a==b), lt = (a<b), and done within 2 cycles of every start.
- WIDTH=8, DIGIT=2, unsigned, early exit:
  - a=0xA5, b=0x25 -> done 1 cycle after the accepting edge, gt=1.
  - a=0x30, b=0x31 -> done after 4 cycles, lt=1.
  - a=b=0x3C -> done after 4 cycles, eq=1.
- SIGNED=1, WIDTH=8, DIGIT=2:
  - a=0x80 (-128), b=0x01 -> lt=1 in 1 cycle.
  - a=0xFF (-1), b=0xFE (-2) -> gt=1 in 4 cycles.
  - a=0x7F, b=0x80 -> gt=1.
- Handshake:
  - Pulse start with a=0x10, b=0x11, then hold start=1 with a=0xFF, b=0x00 while busy -> first result lt=1 after 4 cycles.
  - The held start is accepted on the done cycle -> gt=1 one cycle later, with no idle gap.
- Reset mid-operation:
  - Start a=b=0x55, assert rst in cycle 2 -> busy, done, gt, eq and lt drop to 0 immediately, with no done pulse.
  - After release, start a=0x02, b=0x01 -> gt=1 in 4 cycles.
